// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stage controller: hazard classes, FSM states
// and the control word that turns an ID_EX slot into a bubble.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_NONE  = 2'b00,
        HZ_BUB   = 2'b01,
        HZ_FLUSH = 2'b10,
        HZ_FRZ   = 2'b11
    } haz_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [5:0] NOP_CTRL = 6'b111111;

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state always uses non-blocking assignment so every register
        // samples its inputs from before the edge.
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Hazard-driven stall/flush/bubble sequencer for the PC and pipeline registers.
// IDLE reacts to haz_type in the same cycle; the other states replay a fixed pattern.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              NSTG      = 5,
    parameter int              BUB_LEN   = 1,
    parameter logic [NSTG-2:0] FLUSH_MSK = (NSTG-1)'(2),
    parameter int              CW        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      haz_type,
    input  logic [CW-1:0]   frz_len,
    output logic [NSTG-2:0] stall,
    output logic [NSTG-2:0] flush,
    output logic            nop,
    output logic            busy,
    output logic [15:0]     stall_cyc
);

    localparam logic [NSTG-2:0] BUB_STALL = (NSTG-1)'(3);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   BUB_CNT   = CW'(BUB_LEN - 1);

    haz_t            haz;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NSTG-2:0] stall_d, flush_d;
    logic            nop_d;

    assign haz = haz_t'(haz_type);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        stall_d = '0;
        flush_d = '0;
        nop_d   = 1'b0;
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                case (haz)
                    HZ_BUB: begin
                        nop_d   = 1'b1;
                        stall_d = BUB_STALL;
                        if (BUB_LEN > 1) begin
                            state_n = BUBBLE;
                            cnt_n   = BUB_CNT;
                        end
                    end
                    HZ_FLUSH: begin
                        flush_d = FLUSH_MSK;
                        state_n = FLUSH;
                    end
                    HZ_FRZ: begin
                        stall_d = '1;
                        // frz_len of 0 or 1 is a single-cycle freeze served entirely here
                        if (frz_len > CNT_ONE) begin
                            state_n = FREEZE;
                            cnt_n   = frz_len - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
            BUBBLE: begin
                if (haz == HZ_FLUSH) begin
                    flush_d = FLUSH_MSK;
                    state_n = FLUSH;
                    cnt_n   = '0;
                end else begin
                    nop_d   = 1'b1;
                    stall_d = BUB_STALL;
                    cnt_n   = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) state_n = IDLE;
                end
            end
            FREEZE: begin
                stall_d = '1;
                cnt_n   = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) state_n = IDLE;
            end
            FLUSH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // IDLE decodes haz_type directly, so reset must mask the outputs explicitly.
    assign stall = rst_n ? stall_d : '0;
    assign flush = rst_n ? flush_d : '0;
    assign nop   = rst_n & nop_d;
    assign busy  = (state != IDLE);

    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall[0]),
        .count (stall_cyc)
    );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: a queue-of-pending-frames model checked
// every cycle, plus directed vectors with literal expectations.
module tb_pipe_stage_ctrl;

    localparam int NSTG    = 5;
    localparam int BUB_LEN = 3;
    localparam int CW      = 4;
    localparam int NR      = NSTG - 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [1:0]    haz_type = 2'b00;
    logic [CW-1:0] frz_len  = '0;
    logic [NR-1:0] stall, flush;
    logic          nop, busy;
    logic [15:0]   stall_cyc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NR-1:0] stall;
        logic [NR-1:0] flush;
        logic          nop;
        bit            bub;
    } frame_t;

    frame_t q[$];
    int     m_cnt = 0;

    pipe_stage_ctrl #(
        .NSTG      (NSTG),
        .BUB_LEN   (BUB_LEN),
        .FLUSH_MSK (4'b0010),
        .CW        (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .haz_type  (haz_type),
        .frz_len   (frz_len),
        .stall     (stall),
        .flush     (flush),
        .nop       (nop),
        .busy      (busy),
        .stall_cyc (stall_cyc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t mk(input logic [NR-1:0] s, input logic [NR-1:0] f,
                                  input logic n, input bit b);
        frame_t fr;
        fr.stall = s;
        fr.flush = f;
        fr.nop   = n;
        fr.bub   = b;
        return fr;
    endfunction

    // Model: queue holds the frames still owed by an accepted hazard; empty queue == idle.
    always @(negedge clk) begin
        frame_t e;
        bit     e_busy;
        int     n;
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            e      = mk('0, '0, 1'b0, 1'b0);
            e_busy = 1'b0;
        end else begin
            e_busy = (q.size() != 0);
            if (q.size() == 0) begin
                case (haz_type)
                    2'b01: begin
                        e = mk(4'b0011, '0, 1'b1, 1'b1);
                        for (int i = 1; i < BUB_LEN; i++) q.push_back(mk(4'b0011, '0, 1'b1, 1'b1));
                    end
                    2'b10: begin
                        e = mk('0, 4'b0010, 1'b0, 1'b0);
                        q.push_back(mk('0, '0, 1'b0, 1'b0));
                    end
                    2'b11: begin
                        e = mk(4'b1111, '0, 1'b0, 1'b0);
                        n = (frz_len == 0) ? 1 : int'(frz_len);
                        for (int i = 1; i < n; i++) q.push_back(mk(4'b1111, '0, 1'b0, 1'b0));
                    end
                    default: e = mk('0, '0, 1'b0, 1'b0);
                endcase
            end else if (q[0].bub && haz_type == 2'b10) begin
                e = mk('0, 4'b0010, 1'b0, 1'b0);
                q.delete();
                q.push_back(mk('0, '0, 1'b0, 1'b0));
            end else begin
                e = q.pop_front();
            end
        end
        check("model.stall", stall, e.stall);
        check("model.flush", flush, e.flush);
        check("model.nop", nop, e.nop);
        check("model.busy", busy, e_busy);
        check("model.stall_cyc", stall_cyc, m_cnt[15:0]);
        check("model.overlap", stall & flush, '0);
        if (e.stall[0] && m_cnt < 65535) m_cnt++;
    end

    task automatic tick(input logic [1:0] h, input logic [CW-1:0] f, input logic r);
        @(posedge clk);
        #1;
        haz_type = h;
        frz_len  = f;
        rst_n    = r;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [NR-1:0] s, input logic [NR-1:0] f,
                              input logic n, input logic b, input logic [15:0] sc);
        check({tag, ".stall"}, stall, s);
        check({tag, ".flush"}, flush, f);
        check({tag, ".nop"}, nop, n);
        check({tag, ".busy"}, busy, b);
        check({tag, ".stall_cyc"}, stall_cyc, sc);
    endtask

    initial begin
        // reset masks a live freeze request
        tick(2'b11, 4'd4, 1'b0); expect_out("rst0", 4'b0000, 4'b0000, 0, 0, 16'd0);
        tick(2'b11, 4'd4, 1'b0); expect_out("rst1", 4'b0000, 4'b0000, 0, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b1); expect_out("idle", 4'b0000, 4'b0000, 0, 0, 16'd0);

        // load-use, BUB_LEN=3, one-cycle request
        tick(2'b01, 4'd0, 1'b1); expect_out("bub1", 4'b0011, 4'b0000, 1, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b1); expect_out("bub2", 4'b0011, 4'b0000, 1, 1, 16'd1);
        tick(2'b00, 4'd0, 1'b1); expect_out("bub3", 4'b0011, 4'b0000, 1, 1, 16'd2);
        tick(2'b00, 4'd0, 1'b1); expect_out("bub_end", 4'b0000, 4'b0000, 0, 0, 16'd3);

        // branch flush, then one quiet FLUSH cycle that ignores haz_type
        tick(2'b10, 4'd0, 1'b1); expect_out("fl1", 4'b0000, 4'b0010, 0, 0, 16'd3);
        tick(2'b10, 4'd0, 1'b1); expect_out("fl_gap", 4'b0000, 4'b0000, 0, 1, 16'd3);
        tick(2'b00, 4'd0, 1'b1); expect_out("fl_end", 4'b0000, 4'b0000, 0, 0, 16'd3);

        // freeze of 4 with load-use requests ignored inside it
        tick(2'b11, 4'd4, 1'b1); expect_out("frz1", 4'b1111, 4'b0000, 0, 0, 16'd3);
        tick(2'b01, 4'd4, 1'b1); expect_out("frz2", 4'b1111, 4'b0000, 0, 1, 16'd4);
        tick(2'b01, 4'd4, 1'b1); expect_out("frz3", 4'b1111, 4'b0000, 0, 1, 16'd5);
        tick(2'b01, 4'd4, 1'b1); expect_out("frz4", 4'b1111, 4'b0000, 0, 1, 16'd6);
        tick(2'b00, 4'd0, 1'b1); expect_out("frz_end", 4'b0000, 4'b0000, 0, 0, 16'd7);

        // flush preempts the second bubble cycle
        tick(2'b01, 4'd0, 1'b1); expect_out("pre1", 4'b0011, 4'b0000, 1, 0, 16'd7);
        tick(2'b10, 4'd0, 1'b1); expect_out("pre2", 4'b0000, 4'b0010, 0, 1, 16'd8);
        tick(2'b01, 4'd0, 1'b1); expect_out("pre_gap", 4'b0000, 4'b0000, 0, 1, 16'd8);
        tick(2'b00, 4'd0, 1'b1); expect_out("pre_end", 4'b0000, 4'b0000, 0, 0, 16'd8);

        // frz_len=0 behaves as a single freeze cycle
        tick(2'b11, 4'd0, 1'b1); expect_out("frz0", 4'b1111, 4'b0000, 0, 0, 16'd8);
        tick(2'b00, 4'd0, 1'b1); expect_out("frz0_end", 4'b0000, 4'b0000, 0, 0, 16'd9);

        // reset in cycle 2 of an 8-cycle freeze
        tick(2'b11, 4'd8, 1'b1); expect_out("frz8_1", 4'b1111, 4'b0000, 0, 0, 16'd9);
        tick(2'b00, 4'd0, 1'b0); expect_out("frz8_rst", 4'b0000, 4'b0000, 0, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b1); expect_out("frz8_rel", 4'b0000, 4'b0000, 0, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b1); expect_out("frz8_rel2", 4'b0000, 4'b0000, 0, 0, 16'd0);

        // reset in the middle of a bubble
        tick(2'b01, 4'd0, 1'b1); expect_out("bubr1", 4'b0011, 4'b0000, 1, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b0); expect_out("bubr_rst", 4'b0000, 4'b0000, 0, 0, 16'd0);
        tick(2'b00, 4'd0, 1'b1); expect_out("bubr_rel", 4'b0000, 4'b0000, 0, 0, 16'd0);

        // continuous freezes drive stall_cyc into saturation
        for (int k = 1; k <= 65538; k++) begin
            tick(2'b11, 4'd15, 1'b1);
            if (k == 65535) check("sat.fffe", stall_cyc, 16'hFFFE);
            if (k == 65536) check("sat.ffff", stall_cyc, 16'hFFFF);
            if (k == 65538) check("sat.hold", stall_cyc, 16'hFFFF);
        end
        for (int k = 0; k < 16; k++) tick(2'b00, 4'd0, 1'b1);
        expect_out("sat_end", 4'b0000, 4'b0000, 0, 0, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 Parameter NSTG, default 5, is the number of pipeline stages; there are NSTG-1 stall-controlled registers: index 0 = PC, 1 = IF_ID, 2 = ID_EX, 3 = EX_MEM, and so on.
REQ-002 Parameter BUB_LEN, default 1, is the number of bubble cycles inserted per load-use hazard (range 1..15).
REQ-003 Parameter FLUSH_MSK, default NSTG-1 bits with only bit 1 set, is the set of registers flushed on a branch/jump hazard.
REQ-004 Parameter CW, default 4, is the width of the freeze-length input and the internal down-counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 haz_type  input  2  hazard class: 00 none; 01 load-use bubble; 10 branch/jump flush; 11 freeze.
REQ-008 frz_len  input  CW  freeze length in cycles, sampled only when a freeze is accepted.
REQ-009 stall  output  NSTG-1  per-register hold enable (1 = hold).
REQ-010 flush  output  NSTG-1  per-register clear enable.
REQ-011 nop  output  1  forces ID_EX control bits to 6'b111111 (bubble).
REQ-012 busy  output  1  high while the FSM is not IDLE.
REQ-013 stall_cyc  output  16  saturating count of cycles with stall[0]=1.

Function
REQ-014 The FSM SHALL have the states IDLE, BUBBLE, FREEZE and FLUSH.
REQ-015 In IDLE, outputs SHALL decode combinationally from haz_type in the same cycle; the hazard unit sits in ID and needs zero-latency response.
REQ-016 IDLE, haz_type=00: all outputs SHALL be 0.
REQ-017 IDLE, haz_type=01: nop=1 and stall[1:0]=11 SHALL assert this cycle; if BUB_LEN>1, the next state SHALL be BUBBLE with cnt=BUB_LEN-1, otherwise IDLE.
REQ-018 IDLE, haz_type=10: flush=FLUSH_MSK SHALL assert for exactly this cycle; the next state SHALL be FLUSH.
REQ-019 FLUSH SHALL last one cycle with flush=0 and stall=0 to absorb the redirected fetch, ignore haz_type, and return to IDLE.
REQ-020 IDLE, haz_type=11: all stall bits SHALL be 1 this cycle; cnt SHALL load frz_len-1; the next state SHALL be FREEZE; frz_len=0 SHALL be treated as 1, giving an immediate return to IDLE.
REQ-021 BUBBLE SHALL assert nop=1 and stall[1:0]=11 and decrement cnt, exiting to IDLE after the cycle in which cnt=1.
REQ-022 In BUBBLE, haz_type=10 SHALL preempt: that cycle outputs the flush of REQ-018 with nop=0 and stall=0, and the next state is FLUSH; the bubble is abandoned.
REQ-023 FREEZE SHALL assert all stall bits with nop=0 and flush=0, decrement cnt, ignore haz_type, and exit to IDLE after the cycle in which cnt=1.
REQ-024 Simultaneous-class priority does not arise (haz_type is encoded); the resulting effective priority is freeze > flush > bubble.
REQ-025 stall_cyc SHALL increment on every cycle with stall[0]=1 and saturate at 16'hFFFF without wrapping.
REQ-026 busy SHALL equal (state != IDLE) as a registered-state decode.
REQ-027 stall and flush SHALL never both be 1 for the same register index.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, cnt=0 and stall_cyc=0.
REQ-029 During reset, the stall, flush, nop and busy outputs SHALL all be 0.
REQ-030 Reset mid-BUBBLE or mid-FREEZE SHALL abort the operation with no residual stall after release.

Structure
REQ-031 The hazard encodings (HZ_NONE, HZ_BUB, HZ_FLUSH, HZ_FRZ), the state encodings and the NOP control value 6'b111111 SHALL live in a shared package pipe_ctrl_pkg.
REQ-032 A single sub-module, sat_counter (16-bit, saturating, enable input), SHALL implement stall_cyc; the FSM and down-counter SHALL be inline.

Verification
REQ-033 IDLE, haz_type=01, BUB_LEN=3, held for 1 cycle -> nop=1 and stall=4'b0011 for 3 consecutive cycles, busy=1 for cycles 2-3, then all 0.
REQ-034 haz_type=11, frz_len=4 -> stall=4'b1111 for exactly 4 cycles; haz_type=01 applied during cycles 2-4 is ignored; stall_cyc increases by 4.
REQ-035 haz_type=10 -> flush=4'b0010 for 1 cycle, then 1 FLUSH cycle with all outputs 0, then IDLE.
REQ-036 BUB_LEN=3 with haz_type=10 in the second bubble cycle -> that cycle flush=4'b0010 and nop=0, next cycle state=FLUSH, no third bubble.
REQ-037 frz_len=0 -> exactly 1 freeze cycle; rst_n pulled low in cycle 2 of frz_len=8 -> stall=0 immediately and after release, with stall_cyc=0.
REQ-038 Force stall_cyc to 16'hFFFE, then run 3 stall cycles -> stall_cyc holds at 16'hFFFF.
